// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, engine state encoding and
// the fixed bit permutations built from them (tables use DES numbering, bit 1 = MSB).
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam logic [6:0] IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam logic [6:0] FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam logic [6:0] E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam logic [6:0] P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each S-box is stored row-major: entry index = row * 16 + column.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - int'(IP_TBL[6'(i)]))];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - int'(FP_TBL[6'(i)]))];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - int'(E_TBL[6'(i)]))];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - int'(P_TBL[5'(i)]))];
        return y;
    endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expand R to 48 bits, mix in the subkey,
// compress through the eight S-boxes and apply the P permutation.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;

    // NOTE: every variable here is assigned before it is read on all paths, so no latch is inferred.
    always_comb begin
        x   = e_expand(r_i) ^ k_i;
        s   = '0;
        six = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47:42];
            x   = x << 6;
            // Outer bits select the row, inner four bits the column.
            s   = {s[27:0], SBOX[3'(b)][{six[5], six[0], six[4:1]}]};
        end
        f_o = p_perm(s);
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative single-block DES engine: one Feistel round per clock with an
// external key schedule addressed through key/cnt/round_key.
module des_round_engine
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic [63:0] key,
    output logic [4:0]  cnt,
    input  logic [47:0] round_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);

    state_e      state_q;
    logic [3:0]  rnd_q;
    logic [31:0] l_q, r_q;
    logic [63:0] key_q;
    logic        mode_q;
    logic [63:0] data_out_q;
    logic        out_valid_q;
    logic [31:0] f_out;
    logic [31:0] r_d;

    des_f u_f (
        .r_i (r_q),
        .k_i (round_key),
        .f_o (f_out)
    );

    assign r_d       = l_q ^ f_out;
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign key       = key_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    // Decryption walks the same schedule backwards.
    assign cnt = (state_q == ST_ROUND) ? {1'b0, (mode_q ? 4'd15 - rnd_q : rnd_q)} : 5'd0;

    // NOTE: non-blocking assignments let every register read its pre-edge value within the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        key_q        <= key_in;
                        mode_q       <= decrypt;
                        {l_q, r_q}   <= ip_perm(data_in);
                        rnd_q        <= '0;
                        state_q      <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    l_q <= r_q;
                    r_q <= r_d;
                    if (rnd_q == 4'd15) begin
                        // Last round: output takes the swapped halves {R16, L16}.
                        data_out_q  <= fp_perm({r_d, r_q});
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
